// File: rtl/vppm_rx_frame_sequencer.sv
// Purpose: VPPM frame receiver - preamble edge counting, mid-symbol sampling, MSB-first byte assembly.
// Latency: vppm_in reaches the sampler after SYNC_STAGES clk; a byte is offered one cycle after its 8th strobe.
// Backpressure: one-byte output holding register; a byte completing while the previous one is unaccepted is dropped and flagged.
module vppm_rx_frame_sequencer #(
    parameter int PREAMBLE_EDGES = 7,
    parameter int FRAME_BYTES    = 4,
    parameter int CNT_W          = 25,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vppm_in,
    input  logic        freq_valid,
    input  logic [31:0] period_cycles,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        sample_strobe,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int EDGE_W = $clog2(PREAMBLE_EDGES + 1);
    localparam int BYTE_W = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W:0] PH_ONE = 1;

    state_t              state;
    state_t              nextState;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                vsPrev;
    logic                vs;
    logic                rise;
    logic [CNT_W-1:0]    pField;
    logic                pValid;
    logic [CNT_W-1:0]    pLat;
    logic [CNT_W:0]      pLatExt;
    logic [CNT_W:0]      phase;
    logic [EDGE_W-1:0]   edgeCnt;
    logic [3:0]          bitCnt;
    logic [BYTE_W-1:0]   byteCnt;
    logic [7:0]          shiftReg;
    logic                lastEdge;
    logic                timeout;
    logic                strobeHit;
    logic                phaseLast;
    logic                byteDone;
    logic                frameEnd;
    logic                accept;

    assign vs      = syncReg[SYNC_STAGES-1];
    assign rise    = vs & ~vsPrev;
    assign pField  = period_cycles[CNT_W-1:0];
    // Upper bits beyond the counter width must be zero, otherwise the period would be truncated.
    assign pValid  = (pField >= CNT_W'(4)) && ((period_cycles >> CNT_W) == 32'd0);
    assign pLatExt = {1'b0, pLat};

    assign lastEdge  = rise && (edgeCnt == EDGE_W'(PREAMBLE_EDGES - 1));
    assign timeout   = !rise && (phase == {pLat, 1'b0});
    assign strobeHit = (state == ST_DATA) && (phase == {1'b0, pLat >> 1});
    assign phaseLast = (phase == (pLatExt - PH_ONE));
    // Byte completion is handled the cycle after the 8th strobe, when bitCnt has reached 8.
    assign byteDone  = (state == ST_DATA) && (bitCnt == 4'd8);
    assign frameEnd  = byteDone && (byteCnt == BYTE_W'(FRAME_BYTES - 1));
    assign accept    = byte_valid && byte_ready;

    // Line synchroniser plus previous-value flop for rise detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syncReg <= '0;
            vsPrev  <= 1'b0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], vppm_in};
            vsPrev  <= vs;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; dropping enable aborts from any state.
    always_comb begin
        nextState = state;
        if (!enable) begin
            nextState = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (freq_valid && pValid) nextState = ST_PREAMBLE;
                ST_PREAMBLE: begin
                    if (lastEdge)     nextState = ST_DATA;
                    else if (timeout) nextState = ST_IDLE;
                end
                ST_DATA:     if (frameEnd) nextState = ST_DONE;
                ST_DONE:     nextState = ST_IDLE;
                default:     nextState = ST_IDLE;
            endcase
        end
    end

    // Phase, edge, bit and byte counters plus the bit shifter; the period is latched only when leaving IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pLat     <= '0;
            phase    <= '0;
            edgeCnt  <= '0;
            bitCnt   <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
        end else if (!enable) begin
            phase    <= '0;
            edgeCnt  <= '0;
            bitCnt   <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    phase   <= '0;
                    edgeCnt <= '0;
                    bitCnt  <= '0;
                    byteCnt <= '0;
                    if (freq_valid && pValid) pLat <= pField;
                end
                ST_PREAMBLE: begin
                    if (rise) begin
                        phase    <= '0;
                        edgeCnt  <= lastEdge ? '0 : edgeCnt + 1'b1;
                        bitCnt   <= '0;
                        byteCnt  <= '0;
                        shiftReg <= '0;
                    end else if (timeout) begin
                        phase   <= '0;
                        edgeCnt <= '0;
                    end else begin
                        phase <= phase + PH_ONE;
                    end
                end
                ST_DATA: begin
                    phase <= phaseLast ? '0 : phase + PH_ONE;
                    if (strobeHit) begin
                        shiftReg <= {shiftReg[6:0], ~vs};
                        bitCnt   <= bitCnt + 1'b1;
                    end else if (byteDone) begin
                        bitCnt  <= '0;
                        byteCnt <= byteCnt + 1'b1;
                    end
                end
                default: begin
                    phase   <= '0;
                    edgeCnt <= '0;
                    bitCnt  <= '0;
                    byteCnt <= '0;
                end
            endcase
        end
    end

    // Output holding register and sticky overrun; a pending byte outlives the frame and enable=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (enable && byteDone && (!byte_valid || accept)) begin
                byte_data  <= shiftReg;
                byte_valid <= 1'b1;
            end else if (accept) begin
                byte_valid <= 1'b0;
            end
            if (!enable) begin
                overrun_err <= 1'b0;
            end else if (byteDone && byte_valid && !accept) begin
                overrun_err <= 1'b1;
            end
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy          = (state != ST_IDLE);
        frame_done    = (state == ST_DONE);
        sample_strobe = strobeHit;
    end

endmodule
